// File: rtl/bullet_scheduler.sv
// bullet_scheduler: frame-tick generator, fire arbiter and erase/redraw sweep
// sequencer for a pool of NUM_SLOTS bullet FSMs sharing one drawing datapath.
//
// Optional feature macro: BULLET_SCHED_AUTOFIRE_EN
//   defined   : holding spacePressed re-arms a fire each time cooldown reaches 0
//   undefined : only rising edges of spacePressed request a fire
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   spacePressed   key level from keyboard decoder
//   slotIdle       per-slot "bullet in reset state" flags
//   drawDone       one-cycle pulse: drawer finished the current slot
//   fire           one-hot launch pulse to the lowest free slot
//   updatePosition one-hot advance pulse to the slot owning the drawer
//   activeSlot     index of the slot currently owning the drawer
//   sweepBusy      high while a sweep is in progress
//   fireDropped    pulse: a press was discarded (cooldown or no free slot)
//   tickOverrun    pulse: a tick arrived while one was still pending
module bullet_scheduler #(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned TICK_DIV       = 833333,
  parameter int unsigned COOLDOWN_TICKS = 8,
  parameter int unsigned WAIT_TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         spacePressed,
  input  logic [NUM_SLOTS-1:0]         slotIdle,
  input  logic                         drawDone,
  output logic [NUM_SLOTS-1:0]         fire,
  output logic [NUM_SLOTS-1:0]         updatePosition,
  output logic [$clog2(NUM_SLOTS)-1:0] activeSlot,
  output logic                         sweepBusy,
  output logic                         fireDropped,
  output logic                         tickOverrun
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CD_W  = $clog2(COOLDOWN_TICKS + 2);
  localparam int unsigned WT_W  = $clog2(WAIT_TIMEOUT + 2);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(COOLDOWN_TICKS);
  localparam logic [WT_W-1:0]  WT_LAST   = WT_W'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_SWEEP_ISSUE,
    S_SWEEP_WAIT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] tick_cnt;
  logic [CD_W-1:0]  cooldown;
  logic [WT_W-1:0]  wait_cnt, wait_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             tick_pending, fire_pending, space_q;

  logic             tick, press_edge, press_accept, press_drop, auto_set;
  logic             take_tick, clr_fire, load_cd, drop_fsm;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [NUM_SLOTS-1:0] fire_n, upd_n;
  logic [IDX_W-1:0] active_n;
  logic             sweep_n;

  // Tick and press qualification; a press while one is pending is ignored outright.
  assign tick         = (tick_cnt == TICK_LAST);
  assign press_edge   = spacePressed & ~space_q;
  assign press_accept = press_edge & ~fire_pending & (cooldown == '0);
  assign press_drop   = press_edge & ~fire_pending & (cooldown != '0);

`ifdef BULLET_SCHED_AUTOFIRE_EN
  // Held key re-arms exactly when the cooldown expires on this tick.
  assign auto_set = tick & (cooldown == CD_W'(1)) & spacePressed & ~fire_pending;
`else
  assign auto_set = 1'b0;
`endif

  // Lowest idle slot for launching.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slotIdle[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wait_n    = wait_cnt;
    fire_n    = '0;
    upd_n     = '0;
    active_n  = activeSlot;
    take_tick = 1'b0;
    clr_fire  = 1'b0;
    load_cd   = 1'b0;
    drop_fsm  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire_pending) begin
          state_n = S_FIRE;
        end else if (tick_pending) begin
          take_tick = 1'b1;
          idx_n     = '0;
          state_n   = S_SWEEP_ISSUE;
        end
      end
      S_FIRE: begin
        clr_fire = 1'b1;
        state_n  = S_IDLE;
        if (free_found) begin
          fire_n  = NUM_SLOTS'(1) << free_idx;
          load_cd = 1'b1;
        end else begin
          drop_fsm = 1'b1;
        end
      end
      S_SWEEP_ISSUE: begin
        active_n = idx;
        if (!slotIdle[idx]) begin
          upd_n   = NUM_SLOTS'(1) << idx;
          wait_n  = '0;
          state_n = S_SWEEP_WAIT;
        end else if (idx == IDX_LAST) begin
          state_n = S_IDLE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      S_SWEEP_WAIT: begin
        if (drawDone || (wait_cnt == WT_LAST)) begin
          if (idx == IDX_LAST) begin
            state_n = S_IDLE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = S_SWEEP_ISSUE;
          end
        end else begin
          wait_n = wait_cnt + WT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    sweep_n = (state_n == S_SWEEP_ISSUE) || (state_n == S_SWEEP_WAIT);
  end

  // Tick counter, pending flags, cooldown and sweep bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      fire_pending <= 1'b0;
      cooldown     <= '0;
      space_q      <= 1'b0;
      idx          <= '0;
      wait_cnt     <= '0;
    end else begin
      tick_cnt     <= tick ? '0 : tick_cnt + CNT_W'(1);
      tick_pending <= tick | (tick_pending & ~take_tick);
      fire_pending <= (fire_pending & ~clr_fire) | press_accept | auto_set;
      space_q      <= spacePressed;
      idx          <= idx_n;
      wait_cnt     <= wait_n;
      if (load_cd)                      cooldown <= CD_LOAD;
      else if (tick && cooldown != '0)  cooldown <= cooldown - CD_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fire           <= '0;
      updatePosition <= '0;
      activeSlot     <= '0;
      sweepBusy      <= 1'b0;
      fireDropped    <= 1'b0;
      tickOverrun    <= 1'b0;
    end else begin
      fire           <= fire_n;
      updatePosition <= upd_n;
      activeSlot     <= active_n;
      sweepBusy      <= sweep_n;
      fireDropped    <= press_drop | drop_fsm;
      tickOverrun    <= tick & tick_pending;
    end
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: behavioural reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_bullet_scheduler;

  localparam int NS = 4;
  localparam int TD = 10;
  localparam int CT = 2;
  localparam int WT = 16;

  localparam int P_IDLE  = 0;
  localparam int P_FIRE  = 1;
  localparam int P_ISSUE = 2;
  localparam int P_WAIT  = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          spacePressed = 1'b0;
  logic [NS-1:0] slotIdle = '0;
  logic          drawDone = 1'b0;
  logic [NS-1:0] fire, updatePosition;
  logic [1:0]    activeSlot;
  logic          sweepBusy, fireDropped, tickOverrun;

  int checks = 0;
  int errors = 0;
  int dd_mode = 0;
  int dd_cnt = 0;

  bullet_scheduler #(
    .NUM_SLOTS(NS), .TICK_DIV(TD), .COOLDOWN_TICKS(CT), .WAIT_TIMEOUT(WT)
  ) dut (
    .clk(clk), .resetn(resetn), .spacePressed(spacePressed), .slotIdle(slotIdle),
    .drawDone(drawDone), .fire(fire), .updatePosition(updatePosition),
    .activeSlot(activeSlot), .sweepBusy(sweepBusy), .fireDropped(fireDropped),
    .tickOverrun(tickOverrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_cnt, m_cd, m_idx, m_wait, m_phase;
  bit        m_tp, m_fp, m_sq;
  bit [NS-1:0] m_fire, m_upd;
  bit [1:0]  m_act;
  bit        m_busy, m_drop, m_ovr;

  task automatic model_step();
    bit tk, edg, acc, took, clr, load, nd;
    int nph, nidx, nwait, lo;
    bit [NS-1:0] nf, nu;
    bit [1:0] na;
    tk    = (m_cnt == TD - 1);
    edg   = spacePressed && !m_sq;
    acc   = edg && !m_fp && (m_cd == 0);
    nd    = edg && !m_fp && (m_cd != 0);
`ifdef BULLET_SCHED_AUTOFIRE_EN
    if (tk && m_cd == 1 && spacePressed && !m_fp) acc = 1;
`endif
    nph = m_phase; nidx = m_idx; nwait = m_wait;
    took = 0; clr = 0; load = 0; nf = '0; nu = '0; na = m_act;
    case (m_phase)
      P_IDLE: begin
        if (m_fp) nph = P_FIRE;
        else if (m_tp) begin took = 1; nidx = 0; nph = P_ISSUE; end
      end
      P_FIRE: begin
        clr = 1; nph = P_IDLE; lo = -1;
        for (int i = 0; i < NS; i++) if (slotIdle[i] && lo < 0) lo = i;
        if (lo >= 0) begin nf[lo] = 1'b1; load = 1; end
        else nd = 1;
      end
      P_ISSUE: begin
        na = 2'(m_idx);
        if (!slotIdle[m_idx]) begin nu[m_idx] = 1'b1; nwait = 0; nph = P_WAIT; end
        else if (m_idx == NS - 1) nph = P_IDLE;
        else nidx = m_idx + 1;
      end
      default: begin
        if (drawDone || m_wait == WT) begin
          if (m_idx == NS - 1) nph = P_IDLE;
          else begin nidx = m_idx + 1; nph = P_ISSUE; end
        end else nwait = m_wait + 1;
      end
    endcase
    m_fire = nf; m_upd = nu; m_act = na; m_drop = nd;
    m_ovr  = tk && m_tp;
    m_busy = (nph == P_ISSUE) || (nph == P_WAIT);
    if (load) m_cd = CT;
    else if (tk && m_cd > 0) m_cd = m_cd - 1;
    m_fp    = (m_fp && !clr) || acc;
    m_tp    = tk || (m_tp && !took);
    m_sq    = spacePressed;
    m_cnt   = tk ? 0 : m_cnt + 1;
    m_phase = nph; m_idx = nidx; m_wait = nwait;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt = 0; m_cd = 0; m_idx = 0; m_wait = 0; m_phase = P_IDLE;
      m_tp = 0; m_fp = 0; m_sq = 0;
      m_fire = '0; m_upd = '0; m_act = '0; m_busy = 0; m_drop = 0; m_ovr = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("fire", 32'(fire), 32'(m_fire));
    check("updatePosition", 32'(updatePosition), 32'(m_upd));
    check("activeSlot", 32'(activeSlot), 32'(m_act));
    check("sweepBusy", 32'(sweepBusy), 32'(m_busy));
    check("fireDropped", 32'(fireDropped), 32'(m_drop));
    check("tickOverrun", 32'(tickOverrun), 32'(m_ovr));
  end

  // drawDone source: 0 = never, 1 = three cycles after each updatePosition, 2 = random.
  always @(negedge clk) begin
    case (dd_mode)
      1: begin
        drawDone = 1'b0;
        if (dd_cnt > 0) begin
          dd_cnt--;
          if (dd_cnt == 0) drawDone = 1'b1;
        end else if (updatePosition != '0) dd_cnt = 3;
      end
      2: drawDone = ($urandom_range(0, 5) == 0);
      default: begin drawDone = 1'b0; dd_cnt = 0; end
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nseen, late;
    bit found, seen_fire, seen_drop, any;
    logic [NS-1:0] seq [0:7];

    // Reset state.
    slotIdle = 4'b1111;
    #1;
    check("reset_outputs", 32'({fire, updatePosition, activeSlot, sweepBusy, fireDropped, tickOverrun}), 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Scenario 1: first press fires slot 0 two edges after the sampling edge.
    spacePressed = 1'b1;
    found = 0; n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (fire != '0) begin found = 1; n = i; break; end
    end
    check("s1_fire_seen", 32'(found), 32'h1);
    check("s1_fire_latency", 32'(n), 32'd3);
    check("s1_fire_value", 32'(fire), 32'b0001);
    @(negedge clk);
    check("s1_fire_one_cycle", 32'(fire), 32'h0);
    spacePressed = 1'b0;
    @(negedge clk);
    spacePressed = 1'b1;
    @(negedge clk);
    check("s1_cooldown_drop", 32'(fireDropped), 32'h1);
    any = 0;
    repeat (5) begin @(negedge clk); if (fire != '0) any = 1; end
    check("s1_no_fire_in_cooldown", 32'(any), 32'h0);

    // Scenario 3: no free slot drops the press without loading cooldown.
    spacePressed = 1'b0;
    repeat (30) @(negedge clk);
    slotIdle = 4'b0000;
    spacePressed = 1'b1;
    found = 0; seen_fire = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fire != '0) seen_fire = 1;
      if (fireDropped) begin found = 1; break; end
    end
    check("s3_drop_seen", 32'(found), 32'h1);
    check("s3_no_fire", 32'(seen_fire), 32'h0);
    spacePressed = 1'b0;
    slotIdle = 4'b1111;
    @(negedge clk);
    spacePressed = 1'b1;
    found = 0; seen_drop = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fireDropped) seen_drop = 1;
      if (fire != '0) begin found = 1; break; end
    end
    check("s3_refire_seen", 32'(found), 32'h1);
    check("s3_refire_value", 32'(fire), 32'b0001);
    check("s3_refire_not_dropped", 32'(seen_drop), 32'h0);
    spacePressed = 1'b0;

    // Scenario 2: sweep skips idle slots 0 and 2.
    slotIdle = 4'b0101;
    dd_mode = 1;
    for (int i = 0; i < 200 && sweepBusy; i++) @(negedge clk);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sweepBusy) begin found = 1; break; end
    end
    check("s2_sweep_start", 32'(found), 32'h1);
    nseen = 0; found = 0;
    for (int i = 0; i < 100; i++) begin
      if (updatePosition != '0 && nseen < 8) begin seq[nseen] = updatePosition; nseen++; end
      if (!sweepBusy) begin found = 1; break; end
      @(negedge clk);
    end
    check("s2_sweep_end", 32'(found), 32'h1);
    check("s2_update_count", 32'(nseen), 32'd2);
    check("s2_first_update", 32'(seq[0]), 32'b0010);
    check("s2_second_update", 32'(seq[1]), 32'b1000);

    // Scenario 4: drawDone never comes, slot 0 times out.
    dd_mode = 0;
    slotIdle = 4'b1110;
    for (int i = 0; i < 200 && sweepBusy; i++) @(negedge clk);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (updatePosition != '0) begin found = 1; break; end
    end
    check("s4_update_seen", 32'(found), 32'h1);
    check("s4_update_value", 32'(updatePosition), 32'b0001);
    late = 0; found = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (updatePosition != '0) late = 1;
      if (!sweepBusy) begin found = 1; n = i; break; end
    end
    check("s4_sweep_end", 32'(found), 32'h1);
    check("s4_timeout_cycles", 32'(n), 32'(WT + 1 + 3));
    check("s4_no_extra_update", 32'(late), 32'h0);

    // Scenario 5: long sweeps cause a tick overrun.
    slotIdle = 4'b0000;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tickOverrun) begin found = 1; break; end
    end
    check("s5_overrun_seen", 32'(found), 32'h1);

    // Scenario 6: asynchronous reset in the middle of a wait.
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (updatePosition != '0) begin found = 1; break; end
    end
    check("s6_update_seen", 32'(found), 32'h1);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("s6_async_reset_outputs", 32'({fire, updatePosition, activeSlot, sweepBusy, fireDropped, tickOverrun}), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    any = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (updatePosition != '0) any = 1;
    end
    check("s6_quiet_until_tick", 32'(any), 32'h0);
    @(negedge clk);
    check("s6_first_update_after_tick", 32'(updatePosition), 32'b0001);

    // Randomized traffic with one mid-run reset.
    dd_mode = 2;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) slotIdle = 4'($urandom);
      if ($urandom_range(0, 5) == 0) spacePressed = ~spacePressed;
      if (c == 1000) begin
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
    end
    dd_mode = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Sequences a pool of NUM_SLOTS bullet FSMs that share one erase/redraw drawing datapath.
- Generates the frame-rate tick and converts space-key presses into a one-hot fire pulse to the lowest free slot, with a cooldown.
- On each tick, sweeps the active slots and grants the drawer to one slot at a time, advancing on drawDone or on timeout.
- Sits between the keyboard decoder, the bullet controllers and the shared drawer.

Parameters:
- NUM_SLOTS, 4, number of bullet slots (2..8).
- TICK_DIV, 833333, clk cycles per frame tick (50 MHz / 60).
- COOLDOWN_TICKS, 8, ticks after a fire during which new presses are dropped.
- WAIT_TIMEOUT, 1023, max cycles spent waiting for drawDone per slot.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- spacePressed  in  1  level from keyboard decoder
- slotIdle  in  NUM_SLOTS  per-slot "in reset state" flag from each bullet FSM
- drawDone  in  1  one-cycle pulse from drawer: current slot's erase/redraw finished
- fire  out  NUM_SLOTS  one-hot, one-cycle launch pulse to a slot
- updatePosition  out  NUM_SLOTS  one-hot, one-cycle advance pulse to a slot
- activeSlot  out  $clog2(NUM_SLOTS)  slot index currently owning the drawer
- sweepBusy  out  1  high while a sweep is in progress
- fireDropped  out  1  one-cycle pulse: a press was discarded
- tickOverrun  out  1  one-cycle pulse: a tick arrived while one was already pending

Behaviour:
- Clock and reset: single clock clk; reset resetn is asynchronous, active-low.
- Reset (any time, including mid-sweep):
  - All outputs go to 0 and the FSM returns to S_IDLE.
  - Tick counter, cooldown, tickPending, firePending and the edge register all clear.
  - No pulse is emitted in the cycle after reset is released.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick is asserted when count == TICK_DIV-1, then the counter wraps to 0.
  - On tick: set tickPending; if tickPending was already set, pulse tickOverrun and keep a single pending tick (no queue).
  - If cooldown > 0, decrement it by 1 per tick.
- Press detect:
  - edge = spacePressed & ~spacePressed_q.
  - If edge and cooldown != 0: pulse fireDropped the same cycle.
  - Else if edge: set firePending.
  - A second edge while firePending is set is ignored (no drop pulse).
- FSM states: S_IDLE, S_FIRE, S_SWEEP_ISSUE, S_SWEEP_WAIT.
  - S_IDLE:
    - firePending has priority over tickPending: firePending -> S_FIRE.
    - Else if tickPending: clear tickPending, idx = 0, go to S_SWEEP_ISSUE.
    - Else stay.
  - S_FIRE (1 cycle):
    - Find the lowest i with slotIdle[i] = 1. If found, fire[i] = 1 and cooldown = COOLDOWN_TICKS; if none, pulse fireDropped.
    - Clear firePending and go to S_IDLE.
  - S_SWEEP_ISSUE (1 cycle):
    - activeSlot = idx.
    - If slotIdle[idx] = 0: updatePosition[idx] = 1, clear the wait counter, go to S_SWEEP_WAIT.
    - Else skip the slot: if idx == NUM_SLOTS-1 go to S_IDLE, else idx++ and stay.
  - S_SWEEP_WAIT:
    - On drawDone, or when the wait counter reaches WAIT_TIMEOUT: if idx == NUM_SLOTS-1 go to S_IDLE, else idx++ and go to S_SWEEP_ISSUE.
    - drawDone is ignored in every other state.
  - sweepBusy = 1 in S_SWEEP_ISSUE and S_SWEEP_WAIT.
- Press edges and ticks arriving during a sweep are latched as pending and serviced on return to S_IDLE.
- A slot fired in S_FIRE is swept only from the next sweep onward.
- fire and updatePosition are never asserted in the same cycle, and each is at most one-hot.
- activeSlot holds its last value outside a sweep.

Optional Feature:
- Macro: BULLET_SCHED_AUTOFIRE_EN.
- Defined: while spacePressed stays high, firePending is also set each time cooldown transitions to 0, giving repeat fire every COOLDOWN_TICKS ticks.
- Not defined: only rising edges of spacePressed set firePending; holding the key fires exactly once.

Test Plan:
All scenarios use TICK_DIV=10, NUM_SLOTS=4, COOLDOWN_TICKS=2, WAIT_TIMEOUT=16.
1. slotIdle=4'b1111, raise spacePressed -> fire=4'b0001 for exactly 1 cycle, 2 cycles after the edge; a second press before 2 ticks elapse -> fireDropped pulse and no fire.
2. slotIdle=4'b0101, tick, drawDone returned 3 cycles after each updatePosition -> updatePosition pulses 4'b0010 then 4'b1000, slots 0 and 2 skipped, sweepBusy falls after the second drawDone.
3. slotIdle=4'b0000, press -> fireDropped pulse, fire stays 0, cooldown not loaded (an immediate next press fires once a slot frees).
4. slotIdle=4'b1110, tick, drawDone never asserted -> the FSM leaves slot 0 after 16 wait cycles and the sweep ends; no hang.
5. Hold drawDone low through 2 tick periods -> tickOverrun pulses once at the 2nd tick, and exactly one further sweep follows.
6. Assert resetn=0 mid-S_SWEEP_WAIT -> all outputs 0 asynchronously; after release, no updatePosition until the next tick (10 cycles).
